// File: rtl/addsub_pkg.sv
// Shared types and op encoding for the pipelined add/subtract unit.
package addsub_pkg;

   typedef logic [1:0] addsub_op_t;

   localparam addsub_op_t OP_ADD     = 2'b00;
   localparam addsub_op_t OP_SUB     = 2'b01;
   localparam addsub_op_t OP_ACC_ADD = 2'b10;
   localparam addsub_op_t OP_ACC_SUB = 2'b11;

   // Flag half of a result; the sum half is sized by WIDTH where the struct is built.
   typedef struct packed {
      logic co;
      logic ovf;
   } addsub_flags_t;

   function automatic logic op_is_acc(input addsub_op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_sub(input addsub_op_t op);
      return op[0];
   endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract with carry/borrow, signed overflow and
// optional unsigned saturation.
module addsub_core #(
   parameter int WIDTH = 8,
   parameter bit SAT   = 1'b0
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   logic [WIDTH:0]   full;
   logic [WIDTH-1:0] raw;

   always_comb begin
      // In subtract mode a negative WIDTH+1 bit difference sets the top bit, which is the borrow.
      if (sub) full = {1'b0, x} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
      else     full = {1'b0, x} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      raw = full[WIDTH-1:0];
      co  = full[WIDTH];
      ovf = ((x[WIDTH-1] ^ b[WIDTH-1]) == sub) && (raw[WIDTH-1] != x[WIDTH-1]);
      sum = raw;
      if (SAT && co) sum = sub ? '0 : '1;
   end

endmodule

// File: rtl/dw_addsub_pipe.sv
// Streamed add/sub unit: stage-1 compute, STAGES-1 delay stages, running
// accumulator and a global-stall valid/ready pipeline.
module dw_addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter bit SAT    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      addsub_flags_t    flg;
   } res_t;

   logic             advance;
   logic             accept;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] core_sum;
   logic             core_co;
   logic             core_ovf;
   logic [WIDTH-1:0] acc_q, acc_d;
   res_t [STAGES:1]  res_q, res_d;
   logic [STAGES:1]  vld_q, vld_d;
   logic [STAGES:0]  vld_pipe;

   // Bit 0 is the acceptance strobe; bit STAGES is the output valid.
   assign vld_pipe  = {vld_q, accept};
   assign out_valid = vld_pipe[STAGES];
   assign advance   = !vld_pipe[STAGES] || out_ready;
   assign in_ready  = advance;
   assign accept    = in_valid && advance;

   assign sum = res_q[STAGES].sum;
   assign co  = res_q[STAGES].flg.co;
   assign ovf = res_q[STAGES].flg.ovf;

   always_comb begin
      x = a;
      if (op_is_acc(op)) x = acc_clr ? '0 : acc_q;
   end

   addsub_core #(.WIDTH(WIDTH), .SAT(SAT)) u_core (
      .x   (x),
      .b   (b),
      .ci  (ci),
      .sub (op_is_sub(op)),
      .sum (core_sum),
      .co  (core_co),
      .ovf (core_ovf)
   );

   always_comb begin
      acc_d = acc_q;
      // Updating at acceptance lets back-to-back ACC ops chain without waiting for the pipe.
      if (accept) begin
         if (op_is_acc(op)) acc_d = core_sum;
         else if (acc_clr)  acc_d = '0;
      end

      res_d = res_q;
      vld_d = vld_q;
      if (advance) begin
         res_d[1] = {core_sum, core_co, core_ovf};
         vld_d[1] = accept;
         for (int i = 2; i <= STAGES; i++) begin
            res_d[i] = res_q[i-1];
            vld_d[i] = vld_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         res_q <= '0;
         vld_q <= '0;
      end else begin
         acc_q <= acc_d;
         res_q <= res_d;
         vld_q <= vld_d;
      end
   end

endmodule

// File: tb/tb_dw_addsub_pipe.sv
// Scoreboard bench: one wrap-around and one saturating instance driven in lockstep.
module tb_dw_addsub_pipe;

   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AADD = 2'b10, ASUB = 2'b11;

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       o;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, in_valid, ci, acc_clr, out_ready;
   logic [1:0] op;
   logic [7:0] a, b;
   logic       in_ready0, ov0, co0, ovf0, in_ready1, ov1, co1, ovf1;
   logic [7:0] sum0, sum1;

   exp_t q0[$], q1[$];
   int   acc0, acc1;
   int   n_chk = 0, n_pass = 0;
   logic       stall_prev = 1'b0;
   logic [9:0] snap;

   always #5 clk = ~clk;

   dw_addsub_pipe #(.WIDTH(8), .STAGES(2), .SAT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .op(op), .a(a), .b(b),
      .ci(ci), .acc_clr(acc_clr), .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .co(co0), .ovf(ovf0));

   dw_addsub_pipe #(.WIDTH(8), .STAGES(2), .SAT(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op), .a(a), .b(b),
      .ci(ci), .acc_clr(acc_clr), .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .co(co1), .ovf(ovf1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
   endtask

   // Reference written from integer arithmetic: signed overflow is a range test.
   function automatic exp_t model(input int x, input int bv, input int c, input bit sub, input bit sat);
      exp_t e;
      int   full, sx, sb, sr;
      sx = (x > 127) ? x - 256 : x;
      sb = (bv > 127) ? bv - 256 : bv;
      if (!sub) begin
         full = x + bv + c;
         e.c  = (full > 255);
         sr   = sx + sb + c;
         e.s  = full[7:0];
         if (sat && e.c) e.s = 8'hff;
      end else begin
         full = x - bv - c;
         e.c  = (x < bv + c);
         sr   = sx - sb - c;
         e.s  = full[7:0];
         if (sat && e.c) e.s = 8'h00;
      end
      e.o = (sr > 127) || (sr < -128);
      return e;
   endfunction

   task automatic issue(input logic [1:0] o, input int av, input int bv, input int cv, input bit clr);
      int   n;
      int   x;
      exp_t e;
      n = 0;
      op = o; a = av[7:0]; b = bv[7:0]; ci = cv[0]; acc_clr = clr; in_valid = 1'b1;
      while (!in_ready0) begin
         if (n >= 50) begin
            chk("issue_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         n++;
         @(posedge clk); #2;
      end
      x = o[1] ? (clr ? 0 : acc0) : av;
      e = model(x, bv, cv, o[0], 1'b0);
      if (o[1]) acc0 = e.s; else if (clr) acc0 = 0;
      q0.push_back(e);
      x = o[1] ? (clr ? 0 : acc1) : av;
      e = model(x, bv, cv, o[0], 1'b1);
      if (o[1]) acc1 = e.s; else if (clr) acc1 = 0;
      q1.push_back(e);
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   // Pin the most recent expectation to a hand-derived value.
   task automatic exp0(input logic [7:0] s, input logic c, input logic o);
      q0[q0.size()-1] = '{s, c, o};
   endtask
   task automatic exp1(input logic [7:0] s, input logic c, input logic o);
      q1[q1.size()-1] = '{s, c, o};
   endtask

   task automatic cyc();
      @(posedge clk); #2;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
         cyc();
         n++;
      end
      chk("drain", q0.size() + q1.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) stall_prev = 1'b0;
      else begin
         chk("in_ready0", in_ready0, !ov0 || out_ready);
         chk("in_ready1", in_ready1, !ov1 || out_ready);
         if (ov0 && out_ready) begin
            if (q0.size() == 0) chk("extra_out0", 1, 0);
            else begin
               e = q0.pop_front();
               chk("sum0", sum0, e.s); chk("co0", co0, e.c); chk("ovf0", ovf0, e.o);
            end
         end
         if (ov1 && out_ready) begin
            if (q1.size() == 0) chk("extra_out1", 1, 0);
            else begin
               e = q1.pop_front();
               chk("sum1", sum1, e.s); chk("co1", co1, e.c); chk("ovf1", ovf1, e.o);
            end
         end
         if (ov0 && !out_ready) begin
            if (stall_prev) chk("stall_hold", {sum0, co0, ovf0}, snap);
            snap = {sum0, co0, ovf0};
            stall_prev = 1'b1;
         end else stall_prev = 1'b0;
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = ADD; a = '0; b = '0; ci = 1'b0; acc_clr = 1'b0;
      out_ready = 1'b1; acc0 = 0; acc1 = 0;
      cyc(); cyc();
      chk("rst_out_valid", ov0, 0);
      chk("rst_sum", sum0, 0);
      chk("rst_flags", {co0, ovf0}, 0);
      chk("rst_in_ready", in_ready0, 1);
      chk("rst_out_valid1", ov1, 0);
      rst = 1'b0;
      cyc();

      // Latency: accepted at edge k, valid after edge k+1.
      issue(ADD, 200, 100, 0, 0); exp0(8'd44, 1'b1, 1'b0); exp1(8'd255, 1'b1, 1'b0);
      chk("lat_not_yet", ov0, 0);
      cyc();
      chk("lat_valid", ov0, 1);
      drain();

      issue(SUB, 5, 7, 1, 0);   exp0(8'd253, 1'b1, 1'b0); exp1(8'd0, 1'b1, 1'b0);
      issue(SUB, 128, 1, 0, 0); exp0(8'd127, 1'b0, 1'b1); exp1(8'd127, 1'b0, 1'b1);
      drain();

      issue(AADD, 0, 100, 0, 1); exp0(8'd100, 1'b0, 1'b0);
      issue(AADD, 0, 50, 0, 0);  exp0(8'd150, 1'b0, 1'b1);
      issue(ASUB, 0, 200, 0, 0); exp0(8'd206, 1'b1, 1'b0); exp1(8'd0, 1'b1, 1'b0);
      chk("chain_vld_a", ov0, 1);
      cyc();
      chk("chain_vld_b", ov0, 1);
      cyc();
      chk("chain_vld_end", ov0, 0);
      drain();

      issue(ADD, 250, 10, 0, 0); exp1(8'd255, 1'b1, 1'b0); exp0(8'd4, 1'b1, 1'b0);
      issue(SUB, 3, 9, 0, 0);    exp1(8'd0, 1'b1, 1'b0);   exp0(8'd250, 1'b1, 1'b0);
      issue(AADD, 0, 200, 0, 1); exp1(8'd200, 1'b0, 1'b0);
      issue(AADD, 0, 100, 0, 0); exp1(8'd255, 1'b1, 1'b0); exp0(8'd44, 1'b1, 1'b0);
      issue(AADD, 0, 0, 0, 0);   exp1(8'd255, 1'b0, 1'b0); exp0(8'd44, 1'b0, 1'b0);
      drain();

      // Backpressure mid-stream on four back-to-back ops.
      fork
         begin
            for (int i = 0; i < 4; i++)
               issue(i[0] ? SUB : ADD, $urandom_range(255), $urandom_range(255), $urandom_range(1), 0);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 12; i++)
         issue(2'($urandom_range(3)), $urandom_range(255), $urandom_range(255),
               $urandom_range(1), ($urandom_range(3) == 0));
      drain();

      // Reset with a full, stalled pipe and accumulator at 77.
      @(posedge clk); #1 out_ready = 1'b0; #1;
      issue(AADD, 0, 77, 0, 1);
      issue(ADD, 10, 20, 0, 0);
      chk("full_vld", ov0, 1);
      chk("full_in_ready", in_ready0, 0);
      rst = 1'b1;
      cyc();
      q0.delete(); q1.delete(); acc0 = 0; acc1 = 0;
      chk("rst_flush_vld", ov0, 0);
      chk("rst_flush_vld1", ov1, 0);
      rst = 1'b0; out_ready = 1'b1;
      issue(AADD, 0, 1, 0, 0); exp0(8'd1, 1'b0, 1'b0); exp1(8'd1, 1'b0, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
